// File: rtl/capture_reader_if.sv
// rtl/capture_reader_if.sv - control, capture RAM and packer-side signals of the capture reader
interface capture_reader_if #(
    parameter int ADDR_W = 10,
    parameter int CH_W   = 8
);
    // run control
    logic              start;
    logic              abort;
    logic [2:0]        channel;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   sample_count;
    logic [7:0]        stretch_factor;
    logic              busy;
    logic              done;

    // capture RAM read port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [CH_W-1:0]   mem_rdata;

    // packer side
    logic              sample_out;
    logic              sample_valid;
    logic              flush;

    // reader view
    modport master (
        input  start, abort, channel, start_addr, sample_count, stretch_factor,
        output busy, done,
        output mem_addr, mem_rd_en,
        input  mem_rdata,
        output sample_out, sample_valid, flush
    );

    // environment view: controller, capture RAM and packer
    modport slave (
        output start, abort, channel, start_addr, sample_count, stretch_factor,
        input  busy, done,
        input  mem_addr, mem_rd_en,
        output mem_rdata,
        input  sample_out, sample_valid, flush
    );
endinterface

// File: rtl/capture_reader.sv
// rtl/capture_reader.sv - reads a capture window and feeds one channel bit per frame to the packer
module capture_reader #(
    parameter int ADDR_W = 10,
    parameter int CH_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    capture_reader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EMIT,
        S_PACE,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] REM_ZERO = '0;
    localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      ONE_8    = 8'd1;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W:0]   rem_q, rem_n;
    logic [7:0]        pace_q, pace_n;
    logic [7:0]        seff_q, seff_n;
    logic [2:0]        ch_q, ch_n;
    // FLUSH spends one idle slot (the would-be READ cycle) before the flush
    // strobe, so flush lands a full frame after the last sample.
    logic              armed_q, armed_n;
    logic              bit_q;

    logic              mem_rd_en_q;
    logic              sample_valid_q;
    logic              flush_q;
    logic              done_q;
    logic              busy_q;

    // next-state and counter update logic; abort overrides every transition
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        rem_n   = rem_q;
        pace_n  = pace_q;
        seff_n  = seff_q;
        ch_n    = ch_q;
        armed_n = armed_q;

        case (state_q)
            S_IDLE: begin
                armed_n = 1'b0;
                if (bus.start) begin
                    ch_n   = bus.channel;
                    seff_n = (bus.stretch_factor == 8'd0) ? ONE_8 : bus.stretch_factor;
                    addr_n = bus.start_addr;
                    rem_n  = bus.sample_count;
                    state_n = (bus.sample_count == REM_ZERO) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_n = S_EMIT;
            end
            S_EMIT: begin
                addr_n = addr_q + 1'b1;
                rem_n  = rem_q - REM_ONE;
                if (seff_q == ONE_8) begin
                    pace_n  = 8'd0;
                    state_n = (rem_q == REM_ONE) ? S_FLUSH : S_READ;
                end else begin
                    pace_n  = seff_q - ONE_8;
                    state_n = S_PACE;
                end
            end
            S_PACE: begin
                pace_n = pace_q - ONE_8;
                if (pace_q == ONE_8) begin
                    state_n = (rem_q == REM_ZERO) ? S_FLUSH : S_READ;
                end
            end
            S_FLUSH: begin
                if (!armed_q) begin
                    armed_n = 1'b1;
                end else begin
                    armed_n = 1'b0;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (bus.abort && (state_q != S_IDLE)) begin
            state_n = S_IDLE;
            armed_n = 1'b0;
        end
    end

    // state, latched run parameters and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pace_q  <= '0;
            seff_q  <= '0;
            ch_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            rem_q   <= rem_n;
            pace_q  <= pace_n;
            seff_q  <= seff_n;
            ch_q    <= ch_n;
            armed_q <= armed_n;
        end
    end

    // strobes are registered from the state being entered so they align with that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            flush_q        <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            mem_rd_en_q    <= (state_n == S_READ);
            sample_valid_q <= (state_n == S_EMIT);
            flush_q        <= (state_n == S_FLUSH) && armed_n;
            done_q         <= (state_n == S_DONE);
            busy_q         <= (state_n != S_IDLE);
        end
    end

    // hold the last emitted channel bit between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else if (state_q == S_EMIT) begin
            bit_q <= bus.mem_rdata[ch_q];
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_out   = (state_q == S_EMIT) ? bus.mem_rdata[ch_q] : bit_q;
    assign bus.flush        = flush_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_capture_reader.sv
// tb/tb_capture_reader.sv - self-checking bench for capture_reader with frame-timing model and packer model
module tb_capture_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    capture_reader_if #(.ADDR_W(10), .CH_W(8)) bus ();

    capture_reader #(.ADDR_W(10), .CH_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // capture RAM: one cycle read latency
    logic [7:0] ram [1024];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // run model: a run of N samples with frame period P starting its first READ at t0
    bit checking = 1'b0;
    bit m_active = 1'b0;
    int m_t0, m_n, m_p, m_sa, m_ch;
    int m_end = 32'h7fffffff;

    always @(negedge clk) begin
        int rel, total, idx;
        bit e_rd, e_sv, e_fl, e_dn, e_busy;
        e_rd = 0; e_sv = 0; e_fl = 0; e_dn = 0; e_busy = 0; idx = 0;
        if (checking) begin
            if (m_active && cyc >= m_t0 && cyc <= m_end) begin
                rel = cyc - m_t0;
                total = m_n * m_p;
                idx = (m_sa + rel / m_p) % 1024;
                if (m_n == 0) begin
                    e_dn = (rel == 0);
                    e_busy = (rel == 0);
                end else begin
                    e_rd = (rel < total) && (rel % m_p == 0);
                    e_sv = (rel < total) && (rel % m_p == 1);
                    e_fl = (rel == total + 1);
                    e_dn = (rel == total + 2);
                    e_busy = (rel <= total + 2);
                end
            end
            chk("mem_rd_en", bus.mem_rd_en, e_rd);
            chk("sample_valid", bus.sample_valid, e_sv);
            chk("flush", bus.flush, e_fl);
            chk("done", bus.done, e_dn);
            chk("busy", bus.busy, e_busy);
            if (e_rd) chk("mem_addr", bus.mem_addr, idx);
            if (e_sv) chk("sample_out", bus.sample_out, ram[idx][m_ch]);
        end
    end

    // observation log and 7-pixel-per-byte packer model
    int q_addr[$];
    int q_bit[$];
    int q_sv[$];
    int q_fl[$];
    int q_dn[$];
    int busy_cnt = 0;
    int pk_s = 1;
    int pk_n = 0;
    logic [6:0] pk_acc = '0;
    int pk_out[$];

    always @(negedge clk) begin
        if (bus.mem_rd_en) q_addr.push_back(int'(bus.mem_addr));
        if (bus.busy) busy_cnt++;
        if (bus.done) q_dn.push_back(cyc);
        if (bus.sample_valid) begin
            q_bit.push_back(int'(bus.sample_out));
            q_sv.push_back(cyc);
            for (int k = 0; k < pk_s; k++) begin
                pk_acc[pk_n] = bus.sample_out;
                pk_n++;
                if (pk_n == 7) begin
                    pk_out.push_back(int'(pk_acc));
                    pk_acc = '0;
                    pk_n = 0;
                end
            end
        end
        if (bus.flush) begin
            q_fl.push_back(cyc);
            if (pk_n > 0) pk_out.push_back(int'(pk_acc));
            pk_acc = '0;
            pk_n = 0;
        end
    end

    task automatic clear_log();
        q_addr.delete(); q_bit.delete(); q_sv.delete(); q_fl.delete(); q_dn.delete();
        pk_out.delete(); pk_acc = '0; pk_n = 0; busy_cnt = 0;
    endtask

    task automatic start_run(input int sa, input int cnt, input int sf, input int ch);
        @(posedge clk); #2;
        bus.start_addr = 10'(sa);
        bus.sample_count = 11'(cnt);
        bus.stretch_factor = 8'(sf);
        bus.channel = 3'(ch);
        bus.start = 1'b1;
        m_t0 = cyc + 1;
        m_n = cnt;
        m_p = ((sf == 0) ? 1 : sf) + 1;
        m_sa = sa;
        m_ch = ch;
        m_end = 32'h7fffffff;
        m_active = 1'b1;
        pk_s = (sf == 0) ? 1 : sf;
        @(posedge clk); #2;
        bus.start = 1'b0;
        // scramble the inputs: the run must use its latched copies
        bus.start_addr = 10'h3ff;
        bus.sample_count = 11'd7;
        bus.stretch_factor = 8'd9;
        bus.channel = 3'd7;
    endtask

    task automatic wait_run();
        repeat (m_n * m_p + 6) @(posedge clk);
        m_active = 1'b0;
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_sample_valid"}, bus.sample_valid, 0);
        chk({tag, "_flush"}, bus.flush, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    endtask

    int sv0[$];
    int guard;

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.channel = '0;
        bus.start_addr = '0;
        bus.sample_count = '0;
        bus.stretch_factor = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'((i * 37 + 11) & 8'hff);
        repeat (3) @(posedge clk);
        #1;
        chk_quiet_outputs("reset");
        chk("reset_sample_out", bus.sample_out, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        checking = 1'b1;

        // basic window, stretch 3
        ram[5] = 8'h04; ram[6] = 8'h00; ram[7] = 8'h04; ram[8] = 8'h04;
        clear_log();
        start_run(5, 4, 3, 2);
        wait_run();
        chk("t1_nsamples", q_bit.size(), 4);
        if (q_bit.size() == 4) begin
            chk("t1_bit0", q_bit[0], 1); chk("t1_bit1", q_bit[1], 0);
            chk("t1_bit2", q_bit[2], 1); chk("t1_bit3", q_bit[3], 1);
            chk("t1_addr0", q_addr[0], 5); chk("t1_addr3", q_addr[3], 8);
            chk("t1_period", q_sv[1] - q_sv[0], 4);
        end
        if (q_fl.size() == 1 && q_sv.size() == 4) chk("t1_flush_gap", q_fl[0] - q_sv[3], 4);
        else chk("t1_flush_count", q_fl.size(), 1);
        if (q_dn.size() == 1 && q_fl.size() == 1) chk("t1_done_gap", q_dn[0] - q_fl[0], 1);
        else chk("t1_done_count", q_dn.size(), 1);
        chk("t1_busy_cycles", busy_cnt, 4 * 4 + 3);

        // stretch 0 and stretch 1 give identical timing
        clear_log();
        start_run(40, 3, 0, 1);
        wait_run();
        sv0 = q_sv;
        for (int i = 0; i < sv0.size(); i++) sv0[i] = sv0[i] - m_t0;
        chk("t2_s0_flush_gap", (q_fl.size() == 1 && q_sv.size() == 3) ? q_fl[0] - q_sv[2] : -1, 2);
        clear_log();
        start_run(40, 3, 1, 1);
        wait_run();
        chk("t2_s1_nsamples", q_sv.size(), 3);
        for (int i = 0; i < 3 && i < q_sv.size() && i < sv0.size(); i++)
            chk("t2_same_timing", q_sv[i] - m_t0, sv0[i]);
        if (q_sv.size() == 3) chk("t2_period", q_sv[1] - q_sv[0], 2);

        // address wrap
        clear_log();
        start_run(1022, 4, 2, 5);
        wait_run();
        chk("t3_naddr", q_addr.size(), 4);
        if (q_addr.size() == 4) begin
            chk("t3_addr0", q_addr[0], 1022); chk("t3_addr1", q_addr[1], 1023);
            chk("t3_addr2", q_addr[2], 0);    chk("t3_addr3", q_addr[3], 1);
        end

        // empty window
        clear_log();
        start_run(9, 0, 4, 0);
        wait_run();
        chk("t4_reads", q_addr.size(), 0);
        chk("t4_strobes", q_sv.size(), 0);
        chk("t4_flushes", q_fl.size(), 0);
        chk("t4_dones", q_dn.size(), 1);
        chk("t4_busy_cycles", busy_cnt, 1);

        // abort after the 2nd sample, with an ignored second start
        clear_log();
        start_run(100, 10, 7, 3);
        @(posedge clk); #2;
        bus.sample_count = 11'd2;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        guard = 0;
        while (q_sv.size() < 2 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("t5_reached_2nd", q_sv.size(), 2);
        #2;
        bus.abort = 1'b1;
        m_end = cyc;
        @(posedge clk); #2;
        bus.abort = 1'b0;
        repeat (30) @(posedge clk);
        m_active = 1'b0;
        chk("t5_strobes", q_sv.size(), 2);
        chk("t5_flushes", q_fl.size(), 0);
        chk("t5_dones", q_dn.size(), 0);
        clear_log();
        start_run(3, 3, 1, 0);
        wait_run();
        chk("t5_restart_dones", q_dn.size(), 1);
        chk("t5_restart_strobes", q_sv.size(), 3);

        // full-depth window
        clear_log();
        start_run(100, 1024, 0, 6);
        wait_run();
        chk("t6_nreads", q_addr.size(), 1024);
        if (q_addr.size() == 1024) chk("t6_last_addr", q_addr[1023], 99);

        // async reset mid-PACE
        clear_log();
        start_run(0, 5, 4, 0);
        guard = 0;
        while (q_sv.size() < 1 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #3;
        rst_n = 1'b0;
        m_active = 1'b0;
        #1;
        chk_quiet_outputs("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        chk("t7_dones", q_dn.size(), 0);
        chk("t7_flushes", q_fl.size(), 0);

        // chained with the packer: 5 ones stretched by 2 -> 0x7F then 0x07
        for (int i = 20; i < 25; i++) ram[i] = 8'hff;
        clear_log();
        start_run(20, 5, 2, 3);
        wait_run();
        chk("t8_nbytes", pk_out.size(), 2);
        if (pk_out.size() == 2) begin
            chk("t8_byte0", pk_out[0], 8'h7f);
            chk("t8_byte1", pk_out[1], 8'h07);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
